// File: rtl/classificador_pkg.sv
// Shared constants and state type for the digit classifier.
// Sized for 11x11 templates of 8-bit differences compared against 10 digits.
package classificador_pkg;

  localparam int N_DIGITS = 10;
  localparam int DIM      = 11;
  localparam int PIX_W    = 8;
  localparam int SUM_W    = 15;
  localparam int ROW_W    = 12;
  localparam int DIG_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Widen a row sum to score width without sign extension.
  function automatic logic [SUM_W-1:0] widen_row(input logic [ROW_W-1:0] r);
    return {{(SUM_W-ROW_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/classificador_digito_soma_linha.sv
// Combinational sum of one row of difference pixels.
// A row of DIM maximal pixels (11*255 = 2805) fits in ROW_W bits.
module soma_linha
  import classificador_pkg::*;
(
  input  logic [DIM-1:0][PIX_W-1:0] pix,
  output logic [ROW_W-1:0]          sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < DIM; i++) begin
      sum = sum + {{(ROW_W-PIX_W){1'b0}}, pix[i]};
    end
  end

endmodule

// File: rtl/classificador_digito.sv
// Serial minimum-score classifier: accumulates one template row per clock,
// keeps the lowest total and reports the winning digit on a one-cycle valid.
module classificador_digito
  import classificador_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIM-1:0][PIX_W-1:0] diff_row,
  output logic [DIG_W-1:0]          digit_sel,
  output logic [DIG_W-1:0]          row_sel,
  output logic                      busy,
  output logic                      valid,
  output logic [DIG_W-1:0]          digit_out,
  output logic [SUM_W-1:0]          score_out
);

  localparam logic [DIG_W-1:0] LAST_ROW   = DIG_W'(DIM - 1);
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(N_DIGITS - 1);

  state_t             state, state_nxt;
  logic [SUM_W-1:0]   acc, acc_nxt;
  logic [SUM_W-1:0]   best_score, best_score_nxt;
  logic [DIG_W-1:0]   best_digit, best_digit_nxt;
  logic [DIG_W-1:0]   digit_sel_nxt, row_sel_nxt;
  logic               busy_nxt, valid_nxt;
  logic [DIG_W-1:0]   digit_out_nxt;
  logic [SUM_W-1:0]   score_out_nxt;
  logic [ROW_W-1:0]   row_sum;
  logic               win;

  soma_linha u_soma_linha (
    .pix (diff_row),
    .sum (row_sum)
  );

  // Strict compare: on a tie the earlier (lower) digit is kept.
  assign win = (acc < best_score);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (row_sel == LAST_ROW) state_nxt = COMPARE;
      COMPARE: state_nxt = (digit_sel == LAST_DIGIT) ? DONE : ACCUM;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers are loaded on the COMPARE->DONE edge so valid is
  // visible during the DONE cycle itself.
  always_comb begin
    acc_nxt        = acc;
    best_score_nxt = best_score;
    best_digit_nxt = best_digit;
    digit_sel_nxt  = digit_sel;
    row_sel_nxt    = row_sel;
    busy_nxt       = busy;
    valid_nxt      = 1'b0;
    digit_out_nxt  = digit_out;
    score_out_nxt  = score_out;
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt       = 1'b1;
          digit_sel_nxt  = '0;
          row_sel_nxt    = '0;
          acc_nxt        = '0;
          best_score_nxt = '1;
        end
      end
      ACCUM: begin
        acc_nxt = acc + widen_row(row_sum);
        if (row_sel < LAST_ROW) row_sel_nxt = row_sel + 1'b1;
      end
      COMPARE: begin
        if (win) begin
          best_score_nxt = acc;
          best_digit_nxt = digit_sel;
        end
        if (digit_sel < LAST_DIGIT) begin
          digit_sel_nxt = digit_sel + 1'b1;
          row_sel_nxt   = '0;
          acc_nxt       = '0;
        end else begin
          valid_nxt     = 1'b1;
          busy_nxt      = 1'b0;
          digit_out_nxt = win ? digit_sel : best_digit;
          score_out_nxt = win ? acc : best_score;
        end
      end
      DONE: begin
        valid_nxt = 1'b0;
      end
      default: begin
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      best_score <= '1;
      best_digit <= '0;
      digit_sel  <= '0;
      row_sel    <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      digit_out  <= '0;
      score_out  <= '0;
    end else begin
      acc        <= acc_nxt;
      best_score <= best_score_nxt;
      best_digit <= best_digit_nxt;
      digit_sel  <= digit_sel_nxt;
      row_sel    <= row_sel_nxt;
      busy       <= busy_nxt;
      valid      <= valid_nxt;
      digit_out  <= digit_out_nxt;
      score_out  <= score_out_nxt;
    end
  end

endmodule

// File: doc/classificador_digito.md
Name: classificador_digito

Overview:
- Downstream stage of the per-digit template difference blocks (Diferenca0..Diferenca9). Each of those produces an 11x11 array of 8-bit per-pixel differences for one digit template.
- This block serially reduces each digit's difference array to a scalar score, one row per clock. It keeps the minimum score and reports the winning digit.
- It drives digit/row select lines to an external combinational mux that presents one 11-pixel row of the selected digit's diff array.

Parameters:
N_DIGITS, 10, number of templates compared
DIM, 11, image side length (rows and pixels per row)
PIX_W, 8, width of one difference pixel
SUM_W, 15, score width; must satisfy 2^SUM_W > DIM*DIM*(2^PIX_W-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse requesting a classification
diff_row  in  [PIX_W-1:0] x [DIM-1:0]  row row_sel of digit digit_sel's diff array (combinational from mux)
digit_sel  out  4  template currently being read
row_sel  out  4  row currently being read
busy  out  1  high from start acceptance until valid
valid  out  1  one-cycle pulse: result ready
digit_out  out  4  winning digit
score_out  out  SUM_W  winning score

Behaviour:
- Reset (async, rst_n=0): state IDLE; digit_sel, row_sel, busy, valid, digit_out, score_out = 0; accumulator = 0; best_score = all ones.
- Timing: all outputs are registered. diff_row is sampled on the same edge that the current digit_sel/row_sel are held, so the upstream mux must be purely combinational.
- IDLE:
  - On start=1: go ACCUM, busy<=1, digit_sel<=0, row_sel<=0, acc<=0, best_score<=all ones.
  - start is ignored in every other state.
- ACCUM:
  - Each edge: acc <= acc + sum of the DIM pixels of diff_row (row sum is 12 bits; zero-extend to SUM_W).
  - If row_sel < DIM-1: row_sel++.
  - Else: go COMPARE.
- COMPARE (one cycle):
  - If acc < best_score (strict): best_score<=acc, best_digit<=digit_sel. Ties keep the lower digit.
  - If digit_sel < N_DIGITS-1: digit_sel++, row_sel<=0, acc<=0, go ACCUM.
  - Else: go DONE.
- DONE (one cycle):
  - valid<=1, digit_out<=best_digit, score_out<=best_score, busy<=0.
  - Next edge: valid<=0, go IDLE.
- Latency: the edge that samples start is E0. valid is high in the cycle after edge N_DIGITS*(DIM+1) (E120 with defaults) and low again after E121.
- Result holding: digit_out and score_out hold until the next DONE. busy and valid are never high together.
- Overflow: impossible by the SUM_W constraint. Maximum score is 30855 with defaults.
- Reset mid-operation aborts immediately. All outputs return to reset values and no valid is produced.
- start asserted in the DONE cycle is ignored; it is accepted again only in IDLE.

Decomposition:
- Package classificador_pkg:
  - constants N_DIGITS, DIM, PIX_W, SUM_W, ROW_W (=12), DIG_W (=4).
  - state enum {IDLE, ACCUM, COMPARE, DONE}.
- Sub-module soma_linha: combinational adder tree, DIM x PIX_W in -> ROW_W out. Instantiated once.

Test Plan:
- All diff_row pixels 0 for every digit; pulse start -> valid after E120, digit_out=0, score_out=0 (tie resolution to lowest digit).
- Digit 7 rows all pixels =1, all other digits all pixels =2 -> digit_out=7, score_out=121; busy high E0..E120.
- All pixels 255 for every digit -> score_out=30855, digit_out=0; no wrap.
- Digit 3 and digit 5 both score 50, others 100 -> digit_out=3. Then a second run with digit 5 at 49 -> digit_out=5. Confirm results held between runs.
- Extra start pulses at E5 and in the DONE cycle -> ignored: single valid at E120, digit_sel sequence unaffected.
- Assert rst_n=0 during digit 4 ACCUM -> busy, valid, digit_out, score_out, digit_sel, row_sel all 0 immediately. A new start after reset produces a correct full run.
